// File: rtl/keypad_scan_reader.sv
// Scans a 4x4 active-low matrix keypad one column at a time, debounces whole-scan
// results, and reports an accepted single key with a one-cycle valid pulse.
module keypad_scan_reader #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  localparam int              CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      STABLE_MAX = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_e;

  logic [3:0]       row_meta_q, row_sync_q;
  logic [CNT_W-1:0] slot_q, slot_d;
  logic [1:0]       col_q, col_d;
  res_kind_e        part_kind_q, part_kind_d;
  logic [3:0]       part_code_q, part_code_d;
  res_kind_e        prev_kind_q, prev_kind_d;
  logic [3:0]       prev_code_q, prev_code_d;
  logic [3:0]       stable_q, stable_d;
  res_kind_e        state_q, state_d;
  logic [3:0]       state_code_q, state_code_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_key_q, multi_key_d;

  logic [3:0] pressed;
  logic [2:0] n_pressed;
  logic [1:0] row_idx;
  res_kind_e  merged_kind;
  logic [3:0] merged_code;
  logic       slot_end, scan_end, same_result;

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

  assign pressed  = ~row_sync_q;
  assign slot_end = (slot_q == SLOT_LAST);
  assign scan_end = slot_end && (col_q == 2'd3);

  // Fold this column's sample into the partial scan result; code is kept 0 unless
  // the result is SINGLE so whole results compare with a plain equality.
  always_comb begin
    n_pressed   = 3'd0;
    row_idx     = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) row_idx = 2'(r);
      n_pressed = n_pressed + {2'b00, pressed[r]};
    end
    merged_kind = part_kind_q;
    merged_code = part_code_q;
    if ((n_pressed >= 3'd2) || ((n_pressed == 3'd1) && (part_kind_q != RES_NONE))) begin
      merged_kind = RES_MULTI;
      merged_code = 4'd0;
    end else if (n_pressed == 3'd1) begin
      merged_kind = RES_SINGLE;
      merged_code = {col_q, row_idx};
    end
  end

  assign same_result = (merged_kind == prev_kind_q) && (merged_code == prev_code_q);

  always_comb begin
    slot_d       = slot_end ? '0 : slot_q + CNT_W'(1);
    col_d        = slot_end ? col_q + 2'd1 : col_q;
    part_kind_d  = part_kind_q;
    part_code_d  = part_code_q;
    prev_kind_d  = prev_kind_q;
    prev_code_d  = prev_code_q;
    stable_d     = stable_q;
    state_d      = state_q;
    state_code_d = state_code_q;
    key_code_d   = key_code_q;
    key_valid_d  = 1'b0;
    key_held_d   = key_held_q;
    multi_key_d  = multi_key_q;

    if (slot_end) begin
      part_kind_d = merged_kind;
      part_code_d = merged_code;
    end

    if (scan_end) begin
      part_kind_d = RES_NONE;
      part_code_d = 4'd0;
      prev_kind_d = merged_kind;
      prev_code_d = merged_code;
      if (!same_result)              stable_d = 4'd1;
      else if (stable_q < STABLE_MAX) stable_d = stable_q + 4'd1;

      if ((stable_d == STABLE_MAX) &&
          ((merged_kind != state_q) || (merged_code != state_code_q))) begin
        state_d      = merged_kind;
        state_code_d = merged_code;
        key_held_d   = (merged_kind == RES_SINGLE);
        multi_key_d  = (merged_kind == RES_MULTI);
        // Any accepted change into SINGLE is a new key, so it always pulses.
        if (merged_kind == RES_SINGLE) begin
          key_code_d  = merged_code;
          key_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      row_meta_q   <= 4'hF;
      row_sync_q   <= 4'hF;
      slot_q       <= '0;
      col_q        <= 2'd0;
      part_kind_q  <= RES_NONE;
      part_code_q  <= 4'd0;
      prev_kind_q  <= RES_NONE;
      prev_code_q  <= 4'd0;
      stable_q     <= 4'd0;
      state_q      <= RES_NONE;
      state_code_q <= 4'd0;
      key_code_q   <= 4'd0;
      key_valid_q  <= 1'b0;
      key_held_q   <= 1'b0;
      multi_key_q  <= 1'b0;
    end else begin
      row_meta_q   <= row_in;
      row_sync_q   <= row_meta_q;
      slot_q       <= slot_d;
      col_q        <= col_d;
      part_kind_q  <= part_kind_d;
      part_code_q  <= part_code_d;
      prev_kind_q  <= prev_kind_d;
      prev_code_q  <= prev_code_d;
      stable_q     <= stable_d;
      state_q      <= state_d;
      state_code_q <= state_code_d;
      key_code_q   <= key_code_d;
      key_valid_q  <= key_valid_d;
      key_held_q   <= key_held_d;
      multi_key_q  <= multi_key_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Bench for keypad_scan_reader: a keypad model drives rows from the column strobe,
// a scan-level reference model predicts accepted keys, a monitor checks pulses.
module tb_keypad_scan_reader;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  logic        m_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in, col_out, key_code;
  logic        key_valid, key_held, multi_key;
  logic [15:0] key_mask = 16'h0000;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q[$];
  int         hist[$];
  int         acc_res;
  logic [3:0] exp_code;

  keypad_scan_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .m_clk(m_clk), .reset(reset), .row_in(row_in), .col_out(col_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .multi_key(multi_key)
  );

  always #5 m_clk = ~m_clk;

  // Physical keypad: a pressed key at (c, r) pulls row r low while column c is driven low.
  function automatic logic [3:0] keypad_rows(logic [3:0] cols, logic [15:0] mask);
    logic [3:0] rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!cols[c] && mask[c*4+r]) rows[r] = 1'b0;
    return rows;
  endfunction

  assign row_in = keypad_rows(col_out, key_mask);

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan result: -1 none, -2 two or more keys, else the single key's code.
  function automatic int scan_result(logic [15:0] m);
    if ($countones(m) == 0) return -1;
    if ($countones(m) > 1)  return -2;
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  // A result is accepted once the last DEB whole scans all agree and differ from the current state.
  task automatic model_scan(logic [15:0] m);
    int  r = scan_result(m);
    bit  all_eq = 1'b1;
    hist.push_back(r);
    if (hist.size() > DEB) void'(hist.pop_front());
    foreach (hist[i]) if (hist[i] != r) all_eq = 1'b0;
    if (hist.size() == DEB && all_eq && r != acc_res) begin
      acc_res = r;
      if (r >= 0) begin
        exp_code = r[3:0];
        exp_q.push_back(r[3:0]);
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    acc_res  = -1;
    exp_code = 4'h0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_col_out"},   16'(col_out),   16'(4'b1110));
    check({tag, "_key_code"},  16'(key_code),  16'h0);
    check({tag, "_key_valid"}, 16'(key_valid), 16'h0);
    check({tag, "_key_held"},  16'(key_held),  16'h0);
    check({tag, "_multi_key"}, 16'(multi_key), 16'h0);
  endtask

  // One full scan with a fixed key set; starts at slot 0 of column 0.
  task automatic do_scan(logic [15:0] m);
    logic [3:0] exp_col;
    key_mask = m;
    model_scan(m);
    for (int i = 0; i < SCAN_LEN; i++) begin
      exp_col = ~(4'b0001 << (i / SCAN_DIV));
      check("col_out", 16'(col_out), 16'(exp_col));
      @(posedge m_clk);
      #1;
    end
    check("key_held",  16'(key_held),  16'(acc_res >= 0));
    check("multi_key", 16'(multi_key), 16'(acc_res == -2));
    check("key_code",  16'(key_code),  16'(exp_code));
  endtask

  task automatic hold(logic [15:0] m, int n);
    for (int i = 0; i < n; i++) do_scan(m);
  endtask

  // Monitor: every key_valid cycle must match the next predicted pulse.
  always @(negedge m_clk) begin
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_key_valid: key_valid=1 key_code=%0h, required no pulse at %0t",
                 key_code, $time);
      end else begin
        check("pulse_key_code", 16'(key_code), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [15:0] m;
    int kind, a, b, n;
    model_reset();
    repeat (3) @(posedge m_clk);
    #1;
    check_reset_outputs("reset");
    @(negedge m_clk);
    reset = 1'b0;

    // Idle: strobe pattern and quiet outputs over 13 scans (208 cycles).
    hold(16'h0000, 13);

    // Key (col 2, row 1) = 9: one pulse, no repeat while held, silent release.
    hold(16'h0200, 3 + 10);
    hold(16'h0000, 4);

    // Bounce on key 0 never accepted, then a stable hold is.
    for (int i = 0; i < 4; i++) begin
      do_scan(16'h0001);
      do_scan(16'h0000);
    end
    hold(16'h0001, 3);

    // Multi (0,0)+(3,3), then release (3,3).
    hold(16'h8001, 4);
    hold(16'h0001, 4);
    hold(16'h0000, 3);

    // Direct change 5 -> A.
    hold(16'h0020, 3);
    hold(16'h0400, 3);

    // Reset inside the column-2 slot while key 9 is accepted.
    hold(16'h0200, 4);
    repeat (2 * SCAN_DIV + 1) @(posedge m_clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    model_reset();
    repeat (2) @(posedge m_clk);
    @(negedge m_clk);
    reset = 1'b0;
    hold(16'h0200, 4);

    // Randomized key sets with random hold lengths.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      m = 16'h0000;
      if (kind == 1 || kind == 2) m[a] = 1'b1;
      if (kind == 3) begin
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      n = $urandom_range(1, 4);
      hold(m, n);
    end
    hold(16'h0000, 3);

    repeat (2) @(negedge m_clk);
    check("pending_pulses", 16'(exp_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
